// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: groups the control unit's datapath-facing signals.
//   slave  modport: used by multicycle_ctrl (takes opcode/flags, drives controls)
//   master modport: used by the datapath side (drives opcode/flags, takes controls)
//   opcode_i[6:0], brflag_i, mem_ready_i               datapath -> control
//   pcwrite_o, irwrite_o, regwrite_o, memread_o,
//   memwrite_o, memtoreg_o, alusrc_o, pcsrc_o,
//   aluop_o[4:0], state_o[2:0], trap_o,
//   cycles_o[31:0], retired_o[31:0]                    control -> datapath
interface multicycle_ctrl_if;
    logic [6:0]  opcode_i;
    logic        brflag_i;
    logic        mem_ready_i;
    logic        pcwrite_o;
    logic        irwrite_o;
    logic        regwrite_o;
    logic        memread_o;
    logic        memwrite_o;
    logic        memtoreg_o;
    logic        alusrc_o;
    logic        pcsrc_o;
    logic [4:0]  aluop_o;
    logic [2:0]  state_o;
    logic        trap_o;
    logic [31:0] cycles_o;
    logic [31:0] retired_o;

    modport slave (
        input  opcode_i, brflag_i, mem_ready_i,
        output pcwrite_o, irwrite_o, regwrite_o, memread_o, memwrite_o,
               memtoreg_o, alusrc_o, pcsrc_o, aluop_o, state_o, trap_o,
               cycles_o, retired_o
    );

    modport master (
        output opcode_i, brflag_i, mem_ready_i,
        input  pcwrite_o, irwrite_o, regwrite_o, memread_o, memwrite_o,
               memtoreg_o, alusrc_o, pcsrc_o, aluop_o, state_o, trap_o,
               cycles_o, retired_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM controller for a multicycle RISC-V style datapath.
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, illegal opcodes park in TRAP.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset; all controls forced low while high
//   bus    : multicycle_ctrl_if.slave (opcode/branch flag/mem ready in,
//            control strobes, aluop, state, trap and perf counters out)
// Optional feature: define MULTICYCLE_PERF_CNT_EN to build the cycle and
// retired-instruction counters; otherwise cycles_o/retired_o are tied to zero.
module multicycle_ctrl (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned ALUOP_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_BRANCH = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_RTYPE  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_ITYPE  = ALUOP_W'(3);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4
    } class_e;

    state_e state_q, state_d;
    class_e class_q, class_d;

    class_e               dec_class_c;
    logic                 legal_c;
    logic                 pcwrite_c;
    logic                 irwrite_c;
    logic                 regwrite_c;
    logic                 memread_c;
    logic                 memwrite_c;
    logic                 memtoreg_c;
    logic                 alusrc_c;
    logic                 pcsrc_c;
    logic                 trap_c;
    logic [ALUOP_W-1:0]   aluop_c;

    // Opcode to instruction class
    always_comb begin
        dec_class_c = C_R;
        legal_c     = 1'b1;
        case (bus.opcode_i)
            OP_R:      dec_class_c = C_R;
            OP_I:      dec_class_c = C_I;
            OP_LOAD:   dec_class_c = C_LOAD;
            OP_STORE:  dec_class_c = C_STORE;
            OP_BRANCH: dec_class_c = C_BRANCH;
            default:   legal_c     = 1'b0;
        endcase
    end

    // State and latched class registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            class_q <= C_R;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Next state and Moore controls; brflag_i/mem_ready_i feed pcsrc/pcwrite directly
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        memtoreg_c = 1'b0;
        alusrc_c   = 1'b0;
        pcsrc_c    = 1'b0;
        trap_c     = 1'b0;
        aluop_c    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                irwrite_c = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                if (legal_c) begin
                    class_d = dec_class_c;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        aluop_c = ALU_RTYPE;
                        state_d = S_WB;
                    end
                    C_I: begin
                        alusrc_c = 1'b1;
                        aluop_c  = ALU_ITYPE;
                        state_d  = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alusrc_c = 1'b1;
                        aluop_c  = ALU_ADD;
                        state_d  = S_MEM;
                    end
                    C_BRANCH: begin
                        aluop_c   = ALU_BRANCH;
                        pcwrite_c = 1'b1;
                        pcsrc_c   = bus.brflag_i;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                alusrc_c   = 1'b1;
                aluop_c    = ALU_ADD;
                memread_c  = (class_q == C_LOAD);
                memwrite_c = (class_q == C_STORE);
                // Wait indefinitely for the memory; a completed store retires here
                if (bus.mem_ready_i) begin
                    if (class_q == C_STORE) begin
                        pcwrite_c = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d   = S_WB;
                    end
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                pcwrite_c  = 1'b1;
                memtoreg_c = (class_q == C_LOAD);
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap_c  = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every control, including the FETCH irwrite strobe
    assign bus.pcwrite_o  = pcwrite_c  & ~rst_i;
    assign bus.irwrite_o  = irwrite_c  & ~rst_i;
    assign bus.regwrite_o = regwrite_c & ~rst_i;
    assign bus.memread_o  = memread_c  & ~rst_i;
    assign bus.memwrite_o = memwrite_c & ~rst_i;
    assign bus.memtoreg_o = memtoreg_c & ~rst_i;
    assign bus.alusrc_o   = alusrc_c   & ~rst_i;
    assign bus.pcsrc_o    = pcsrc_c    & ~rst_i;
    assign bus.trap_o     = trap_c     & ~rst_i;
    assign bus.aluop_o    = rst_i ? ALU_ADD : aluop_c;
    assign bus.state_o    = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] retired_q;

    // Free-running cycle count and count of PC updates, both wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycles_q  <= '0;
            retired_q <= '0;
        end else begin
            cycles_q <= cycles_q + CNT_W'(1);
            if (pcwrite_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.cycles_o  = cycles_q;
    assign bus.retired_o = retired_q;
`else
    assign bus.cycles_o  = '0;
    assign bus.retired_o = '0;
`endif

endmodule
